// File: rtl/stream_comp_ctrl.sv
// Firing controller for a three-phase streaming compute actor.
// Phases run SETUP_COMP -> COMP -> OUTPUT. Each firing pops input tokens,
// spends a fixed number of compute cycles, or pushes output tokens.
// Handshake: a firing starts on a rising edge where invoke=1 and enable=1.
// enable is always 0 while busy=1, so invoke is ignored for a firing's whole
// duration, including its last busy cycle. busy, rd_en, wr_en, mode and done
// are all registered.
module stream_comp_ctrl #(
    parameter int N_IN            = 3,
    parameter int SIZE            = 3,
    parameter int BUFFER_SIZE     = 5,
    parameter int BUFFER_SIZE_OUT = 1,
    parameter int PROD            = 1,
    parameter int COMP_CYCLES     = 4,
    localparam int PW = ($clog2(BUFFER_SIZE + 1) < 1) ? 1 : $clog2(BUFFER_SIZE + 1),
    localparam int OW = ($clog2(BUFFER_SIZE_OUT + 1) < 1) ? 1 : $clog2(BUFFER_SIZE_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              invoke,
    input  logic [N_IN*PW-1:0] pop_in,
    input  logic [OW-1:0]     free_space,
    output logic [1:0]        mode,
    output logic              enable,
    output logic              busy,
    output logic [N_IN-1:0]   rd_en,
    output logic              wr_en,
    output logic              done
);

    // The duration counter must hold the longest firing length minus one.
    localparam int MAX_SP  = (SIZE > PROD) ? SIZE : PROD;
    localparam int MAX_DUR = (MAX_SP > COMP_CYCLES) ? MAX_SP : COMP_CYCLES;
    localparam int CW      = ($clog2(MAX_DUR + 1) < 1) ? 1 : $clog2(MAX_DUR + 1);

    localparam logic [PW-1:0] SIZE_P     = PW'(SIZE);
    localparam logic [OW-1:0] PROD_P     = OW'(PROD);
    localparam logic [CW-1:0] SIZE_LAST  = CW'(SIZE - 1);
    localparam logic [CW-1:0] COMP_LAST  = CW'(COMP_CYCLES - 1);
    localparam logic [CW-1:0] PROD_LAST  = CW'(PROD - 1);

    typedef enum logic [1:0] {
        MODE_SETUP  = 2'b00,
        MODE_COMP   = 2'b01,
        MODE_OUTPUT = 2'b10
    } mode_t;

    mode_t           mode_q;
    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [N_IN-1:0] rd_en_q;
    logic            wr_en_q;
    logic            done_q;
    logic            pops_ok;
    logic            enable_c;

    // Every input channel holds at least SIZE tokens.
    always_comb begin
        pops_ok = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (pop_in[k*PW +: PW] < SIZE_P) pops_ok = 1'b0;
        end
    end

    // Fireability of the current mode; never asserted during a firing.
    always_comb begin
        enable_c = 1'b0;
        if (!busy_q) begin
            case (mode_q)
                MODE_SETUP:  enable_c = pops_ok;
                MODE_COMP:   enable_c = 1'b1;
                MODE_OUTPUT: enable_c = (free_space >= PROD_P);
                default:     enable_c = 1'b0;
            endcase
        end
    end

    // Firing sequencer: start on invoke&enable, count down, advance mode at the end.
    // The length is latched into the counter at the start edge, so population
    // changes during a firing cannot stretch or shorten it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_SETUP;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rd_en_q <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                if (cnt_q == '0) begin
                    busy_q  <= 1'b0;
                    rd_en_q <= '0;
                    wr_en_q <= 1'b0;
                    case (mode_q)
                        MODE_SETUP:  mode_q <= MODE_COMP;
                        MODE_COMP:   mode_q <= MODE_OUTPUT;
                        MODE_OUTPUT: begin
                            mode_q <= MODE_SETUP;
                            done_q <= 1'b1;
                        end
                        default:     mode_q <= MODE_SETUP;
                    endcase
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (invoke && enable_c) begin
                busy_q <= 1'b1;
                case (mode_q)
                    MODE_SETUP: begin
                        cnt_q   <= SIZE_LAST;
                        rd_en_q <= '1;
                    end
                    MODE_COMP: begin
                        cnt_q <= COMP_LAST;
                    end
                    MODE_OUTPUT: begin
                        cnt_q   <= PROD_LAST;
                        wr_en_q <= 1'b1;
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign mode   = mode_q;
    assign enable = enable_c;
    assign busy   = busy_q;
    assign rd_en  = rd_en_q;
    assign wr_en  = wr_en_q;
    assign done   = done_q;

endmodule

// File: tb/tb_stream_comp_ctrl.sv
// Directed bench for stream_comp_ctrl: default instance plus a 4-channel,
// SIZE=4 instance sharing clock and reset.
module tb_stream_comp_ctrl;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance (PW=3, OW=1)
    logic       invoke = 1'b0;
    logic [8:0] pop_in = '0;
    logic [0:0] free_space = '0;
    logic [1:0] mode;
    logic       enable, busy, wr_en, done;
    logic [2:0] rd_en;

    stream_comp_ctrl dut (
        .clk(clk), .rst(rst), .invoke(invoke), .pop_in(pop_in),
        .free_space(free_space), .mode(mode), .enable(enable), .busy(busy),
        .rd_en(rd_en), .wr_en(wr_en), .done(done)
    );

    // wide instance (N_IN=4, SIZE=4, BUFFER_SIZE=4 -> PW=3)
    logic        invoke2 = 1'b0;
    logic [11:0] pop_in2 = '0;
    logic [0:0]  free_space2 = '0;
    logic [1:0]  mode2;
    logic        enable2, busy2, wr_en2, done2;
    logic [3:0]  rd_en2;

    stream_comp_ctrl #(.N_IN(4), .SIZE(4), .BUFFER_SIZE(4)) dut2 (
        .clk(clk), .rst(rst), .invoke(invoke2), .pop_in(pop_in2),
        .free_space(free_space2), .mode(mode2), .enable(enable2), .busy(busy2),
        .rd_en(rd_en2), .wr_en(wr_en2), .done(done2)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        vec_cnt++;
        if (act !== exp_v) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    // sample point: 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic eb, input logic [2:0] er,
                             input logic ew, input logic [1:0] em, input logic ed);
        check({tag, ".busy"},  32'(busy),  32'(eb));
        check({tag, ".rd_en"}, 32'(rd_en), 32'(er));
        check({tag, ".wr_en"}, 32'(wr_en), 32'(ew));
        check({tag, ".mode"},  32'(mode),  32'(em));
        check({tag, ".done"},  32'(done),  32'(ed));
    endtask

    initial begin
        // ---- reset state
        tick();
        tick();
        expect_st("reset", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        check("reset.enable", 32'(enable), 32'd0);
        rst = 1'b1;
        tick();

        // ---- SETUP firing with an invoke pulse; populations drop mid-firing
        pop_in = {3'd3, 3'd3, 3'd3};
        #1;
        check("setup.enable", 32'(enable), 32'd1);
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        expect_st("setup.c1", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        check("setup.c1.enable", 32'(enable), 32'd0);
        tick();
        pop_in = '0;
        expect_st("setup.c2", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        tick();
        expect_st("setup.c3", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        tick();
        expect_st("setup.end", 1'b0, 3'b000, 1'b0, 2'b01, 1'b0);

        // ---- COMP firing: 4 busy cycles without strobes
        check("comp.enable", 32'(enable), 32'd1);
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_st($sformatf("comp.c%0d", i + 1), 1'b1, 3'b000, 1'b0, 2'b01, 1'b0);
            tick();
        end
        expect_st("comp.end", 1'b0, 3'b000, 1'b0, 2'b10, 1'b0);

        // ---- OUTPUT gated by free space
        free_space = 1'b0;
        #1;
        check("out.blocked.enable", 32'(enable), 32'd0);
        invoke = 1'b1;
        tick();
        expect_st("out.blocked", 1'b0, 3'b000, 1'b0, 2'b10, 1'b0);
        free_space = 1'b1;
        #1;
        check("out.enable", 32'(enable), 32'd1);
        tick();
        invoke = 1'b0;
        expect_st("out.c1", 1'b1, 3'b000, 1'b1, 2'b10, 1'b0);
        tick();
        expect_st("out.end", 1'b0, 3'b000, 1'b0, 2'b00, 1'b1);
        tick();
        check("out.done_clear", 32'(done), 32'd0);

        // ---- one short channel blocks SETUP; raising it starts the firing
        pop_in = {3'd3, 3'd2, 3'd3};
        invoke = 1'b1;
        #1;
        check("short.enable", 32'(enable), 32'd0);
        tick();
        tick();
        expect_st("short.wait", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        pop_in = {3'd3, 3'd3, 3'd3};
        #1;
        check("short.raised.enable", 32'(enable), 32'd1);
        tick();

        // ---- invoke held: back-to-back firings with a one-cycle gap each
        expect_st("b2b.s1", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        tick();
        tick();
        expect_st("b2b.s3", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        tick();
        expect_st("b2b.gap1", 1'b0, 3'b000, 1'b0, 2'b01, 1'b0);
        tick();
        expect_st("b2b.comp1", 1'b1, 3'b000, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        tick();
        expect_st("b2b.comp4", 1'b1, 3'b000, 1'b0, 2'b01, 1'b0);
        tick();
        expect_st("b2b.gap2", 1'b0, 3'b000, 1'b0, 2'b10, 1'b0);
        tick();
        expect_st("b2b.out", 1'b1, 3'b000, 1'b1, 2'b10, 1'b0);
        tick();
        expect_st("b2b.gap3", 1'b0, 3'b000, 1'b0, 2'b00, 1'b1);
        invoke = 1'b0;
        tick();
        expect_st("b2b.idle", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);

        // ---- reset during the second rd_en cycle
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        expect_st("rst.c1", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        tick();
        expect_st("rst.c2", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);
        rst = 1'b0;
        #1;
        expect_st("rst.async", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("rst.after%0d", i), 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        end
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        expect_st("rst.refire", 1'b1, 3'b111, 1'b0, 2'b00, 1'b0);

        // ---- wide instance: 4 channels, SIZE=4
        pop_in2 = {3'd4, 3'd3, 3'd4, 3'd4};
        #1;
        check("wide.short.enable", 32'(enable2), 32'd0);
        pop_in2 = {3'd4, 3'd4, 3'd4, 3'd4};
        #1;
        check("wide.enable", 32'(enable2), 32'd1);
        invoke2 = 1'b1;
        tick();
        invoke2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wide.c%0d.busy", i + 1), 32'(busy2), 32'd1);
            check($sformatf("wide.c%0d.rd_en", i + 1), 32'(rd_en2), 32'hf);
            tick();
        end
        check("wide.end.busy", 32'(busy2), 32'd0);
        check("wide.end.rd_en", 32'(rd_en2), 32'd0);
        check("wide.end.mode", 32'(mode2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/stream_comp_ctrl.md
STREAM_COMP_CTRL -- requirements
Module: stream_comp_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, meaning the number of input FIFO channels.
REQ-002 The block SHALL have parameter SIZE, default 3, meaning tokens consumed per channel in SETUP_COMP.
REQ-003 The block SHALL have parameter BUFFER_SIZE, default 5, meaning the input FIFO depth.
REQ-004 The block SHALL have parameter BUFFER_SIZE_OUT, default 1, meaning the output FIFO depth.
REQ-005 The block SHALL have parameter PROD, default 1, meaning tokens produced per OUTPUT firing.
REQ-006 The block SHALL have parameter COMP_CYCLES, default 4, meaning the COMP duration in clocks.
REQ-007 The block SHALL define PW = ceil(log2(BUFFER_SIZE+1)) and OW = ceil(log2(BUFFER_SIZE_OUT+1)), each with a minimum of 1.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit: asynchronous reset, active low.
REQ-010 The block SHALL have port invoke, input, 1 bit: firing request for the current mode.
REQ-011 The block SHALL have port pop_in, input, N_IN*PW bits: packed input FIFO populations, channel k at bits [k*PW +: PW].
REQ-012 The block SHALL have port free_space, input, OW bits: output FIFO free space.
REQ-013 The block SHALL have port mode, output, 2 bits: mode of the next firing; SETUP_COMP=00, COMP=01, OUTPUT=10.
REQ-014 The block SHALL have port enable, output, 1 bit: the current mode is fireable.
REQ-015 The block SHALL have port busy, output, 1 bit: a firing is in progress.
REQ-016 The block SHALL have port rd_en, output, N_IN bits: per-channel input FIFO pop strobes.
REQ-017 The block SHALL have port wr_en, output, 1 bit: output FIFO push strobe.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a full SETUP_COMP/COMP/OUTPUT cycle.

Function
REQ-019 enable SHALL be combinational from mode, busy, pop_in and free_space, and SHALL be 0 whenever busy=1.
REQ-020 In SETUP_COMP, enable SHALL be 1 iff every channel population is >= SIZE.
REQ-021 In COMP, enable SHALL be 1.
REQ-022 In OUTPUT, enable SHALL be 1 iff free_space >= PROD, and 0 otherwise (no held value).
REQ-023 For mode 11, enable SHALL be 0 and invoke SHALL be ignored.
REQ-024 A firing SHALL start on a rising edge where invoke=1 and enable=1; busy SHALL go high from the next cycle.
REQ-025 A SETUP_COMP firing SHALL assert rd_en all-ones for exactly SIZE consecutive cycles beginning the cycle after the start edge.
REQ-026 A COMP firing SHALL hold busy for exactly COMP_CYCLES cycles with rd_en=0 and wr_en=0.
REQ-027 An OUTPUT firing SHALL assert wr_en for exactly PROD consecutive cycles.
REQ-028 On the last busy cycle of a firing, mode SHALL advance on that edge: SETUP_COMP to COMP, COMP to OUTPUT, OUTPUT to SETUP_COMP.
REQ-029 busy SHALL deassert on the same edge on which mode advances.
REQ-030 done SHALL pulse for one cycle coincident with the first cycle after an OUTPUT firing completes.
REQ-031 invoke SHALL be ignored while busy=1, including on the final busy cycle; a new firing requires invoke=1 with enable=1 on a subsequent non-busy cycle.
REQ-032 Back-to-back firing SHALL be supported: invoke held high SHALL restart on the first non-busy cycle if enable=1, leaving a one-cycle gap with busy=0.
REQ-033 The duration counter SHALL be max(SIZE, COMP_CYCLES, PROD) wide in bits rounded up via ceil(log2(.+1)) and SHALL never wrap within a firing.
REQ-034 Populations changing during a firing SHALL not alter that firing's length.
REQ-035 SIZE, PROD and COMP_CYCLES SHALL each be >= 1.
REQ-036 SIZE SHALL be <= BUFFER_SIZE, and PROD SHALL be <= BUFFER_SIZE_OUT.

Reset
REQ-037 When rst=0, asynchronously and regardless of state: mode=SETUP_COMP, busy=0, rd_en=0, wr_en=0, done=0, and the counter cleared.
REQ-038 A firing interrupted by reset SHALL be abandoned, with no further strobes after rst rises.
REQ-039 The first firing after reset release SHALL require a fresh invoke/enable evaluation.

Verification
REQ-040 Defaults; pop_in=3,3,3, invoke pulse -> rd_en=111 for 3 cycles, mode goes 00 to 01, busy high 3 cycles.
REQ-041 Defaults; pop_in=3,2,3 with invoke held -> enable=0, no rd_en; raise channel 1 to 3 -> firing starts on the next edge.
REQ-042 Mode 01 with invoke -> busy high 4 cycles; then mode=10; free_space=0 -> enable=0; free_space=1 -> wr_en for 1 cycle, done pulse, mode=00.
REQ-043 invoke held high through a complete cycle with sufficient tokens -> 1-cycle gap between firings; invoke on the final busy cycle is not accepted early.
REQ-044 rst=0 asserted on the 2nd rd_en cycle -> rd_en drops immediately; after release mode=00, busy=0, no strobes until the next invoke.
REQ-045 N_IN=4, SIZE=4, BUFFER_SIZE=4 (PW=3), pop_in=4 on all channels -> enable=1, rd_en=1111 for 4 cycles; a population of 3 on any channel -> enable=0.
